// File: rtl/control_unit.sv
// control_unit: one-hot Moore sequencer stepping six edge-detection stages in order.
module control_unit (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic gaussian_enable,
  input  logic gaussian_done,
  output logic conv_enable,
  input  logic conv_done,
  output logic filter_enable,
  input  logic filter_done,
  output logic suppress_enable,
  input  logic suppress_done,
  output logic threshold_enable,
  input  logic threshold_done,
  output logic hysterisis_enable,
  input  logic hysterisis_done
);
  typedef enum logic [7:0] {
    IDLE       = 8'b0000_0001,
    GAUSSIAN   = 8'b0000_0010,
    CONV       = 8'b0000_0100,
    FILTER     = 8'b0000_1000,
    SUPPRESS   = 8'b0001_0000,
    THRESHOLD  = 8'b0010_0000,
    HYSTERISIS = 8'b0100_0000,
    COMPLETE   = 8'b1000_0000
  } state_t;
  state_t state;
  // Dropping enable returns to IDLE from every state, so abort beats any done.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else if (!enable) state <= IDLE;
    else
      case (state)
        IDLE:       state <= GAUSSIAN;
        GAUSSIAN:   state <= gaussian_done   ? CONV       : GAUSSIAN;
        CONV:       state <= conv_done       ? FILTER     : CONV;
        FILTER:     state <= filter_done     ? SUPPRESS   : FILTER;
        SUPPRESS:   state <= suppress_done   ? THRESHOLD  : SUPPRESS;
        THRESHOLD:  state <= threshold_done  ? HYSTERISIS : THRESHOLD;
        HYSTERISIS: state <= hysterisis_done ? COMPLETE   : HYSTERISIS;
        COMPLETE:   state <= COMPLETE;
        default:    state <= IDLE;
      endcase
  assign gaussian_enable   = state[1];
  assign conv_enable       = state[2];
  assign filter_enable     = state[3];
  assign suppress_enable   = state[4];
  assign threshold_enable  = state[5];
  assign hysterisis_enable = state[6];
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of the stage sequencer with per-feature tasks.
module tb_control_unit;
  logic clk, reset_n, enable;
  logic [5:0] dn;
  logic [5:0] en;
  int n_checks = 0;
  int n_fail = 0;
  control_unit dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .gaussian_enable(en[5]),   .gaussian_done(dn[5]),
    .conv_enable(en[4]),       .conv_done(dn[4]),
    .filter_enable(en[3]),     .filter_done(dn[3]),
    .suppress_enable(en[2]),   .suppress_done(dn[2]),
    .threshold_enable(en[1]),  .threshold_done(dn[1]),
    .hysterisis_enable(en[0]), .hysterisis_done(dn[0])
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic restart();
    enable = 0;
    dn = 0;
    step();
    enable = 1;
    step();
  endtask
  task automatic advance(input int k);
    for (int i = 0; i < k; i++) begin
      dn = 6'b100000 >> i;
      step();
      dn = 0;
    end
  endtask
  task automatic test_reset();
    reset_n = 1;
    enable = 1;
    dn = 0;
    #2 reset_n = 0;
    #1;
    n_checks++;
    if (en !== 6'b000000) begin n_fail++; $display("FAIL reset_async got %b exp %b", en, 6'b000000); end
    step();
    step();
    n_checks++;
    if (en !== 6'b000000) begin n_fail++; $display("FAIL reset_hold got %b exp %b", en, 6'b000000); end
    #2 reset_n = 1;
    step();
    n_checks++;
    if (en !== 6'b100000) begin n_fail++; $display("FAIL reset_release got %b exp %b", en, 6'b100000); end
  endtask
  task automatic test_full_run();
    logic [5:0] exp;
    restart();
    for (int i = 0; i < 6; i++) begin
      exp = 6'b100000 >> i;
      n_checks++;
      if (en !== exp) begin n_fail++; $display("FAIL run_stage%0d got %b exp %b", i, en, exp); end
      step();
      n_checks++;
      if (en !== exp) begin n_fail++; $display("FAIL run_wait%0d got %b exp %b", i, en, exp); end
      dn = exp;
      step();
      dn = 0;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (en !== 6'b000000) begin n_fail++; $display("FAIL run_complete%0d got %b exp %b", i, en, 6'b000000); end
      step();
    end
    enable = 0;
    step();
    n_checks++;
    if (en !== 6'b000000) begin n_fail++; $display("FAIL run_idle got %b exp %b", en, 6'b000000); end
    enable = 1;
    step();
    n_checks++;
    if (en !== 6'b100000) begin n_fail++; $display("FAIL run_rerun got %b exp %b", en, 6'b100000); end
  endtask
  task automatic test_out_of_order();
    restart();
    advance(1);
    dn = 6'b001010;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (en !== 6'b010000) begin n_fail++; $display("FAIL ooo_cycle%0d got %b exp %b", i, en, 6'b010000); end
    end
    dn = 6'b011100;
    step();
    dn = 0;
    n_checks++;
    if (en !== 6'b001000) begin n_fail++; $display("FAIL ooo_mixed got %b exp %b", en, 6'b001000); end
  endtask
  task automatic test_held_done();
    restart();
    advance(2);
    dn = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (en !== 6'b000100) begin n_fail++; $display("FAIL held_cycle%0d got %b exp %b", i, en, 6'b000100); end
    end
    dn = 0;
  endtask
  task automatic test_abort();
    restart();
    advance(3);
    n_checks++;
    if (en !== 6'b000100) begin n_fail++; $display("FAIL abort_pre got %b exp %b", en, 6'b000100); end
    enable = 0;
    step();
    n_checks++;
    if (en !== 6'b000000) begin n_fail++; $display("FAIL abort_plain got %b exp %b", en, 6'b000000); end
    restart();
    advance(3);
    enable = 0;
    dn = 6'b000100;
    step();
    dn = 0;
    n_checks++;
    if (en !== 6'b000000) begin n_fail++; $display("FAIL abort_with_done got %b exp %b", en, 6'b000000); end
  endtask
  task automatic test_async_reset();
    restart();
    advance(4);
    n_checks++;
    if (en !== 6'b000010) begin n_fail++; $display("FAIL areset_pre got %b exp %b", en, 6'b000010); end
    #3 reset_n = 0;
    #1;
    n_checks++;
    if (en !== 6'b000000) begin n_fail++; $display("FAIL areset_immediate got %b exp %b", en, 6'b000000); end
    #2 reset_n = 1;
    step();
    n_checks++;
    if (en !== 6'b100000) begin n_fail++; $display("FAIL areset_idle got %b exp %b", en, 6'b100000); end
  endtask
  initial begin
    test_reset();
    test_full_run();
    test_out_of_order();
    test_held_done();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
